// File: rtl/bid_bus_master.sv
// Single-beat initiator for the one-hot-addressed bidirectional bank bus.
// Converts valid/ready requests into bus phases and returns a registered response.
module bid_bus_master #(
  parameter int A_WID   = 5,
  parameter int D_WID   = 8,
  parameter int IDX_WID = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [IDX_WID-1:0] req_idx,
  input  logic [D_WID-1:0]   req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [D_WID-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic [A_WID-1:0]   addr,
  output logic               wr,
  output logic               rd,
  inout  wire  [D_WID-1:0]   data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_RSP     = 3'd4;

  localparam logic [IDX_WID:0] LP_NBANK = (IDX_WID + 1)'(A_WID);

  logic [2:0]         r_state;
  logic [IDX_WID-1:0] r_idx;
  logic [D_WID-1:0]   r_wdata;
  logic [D_WID-1:0]   r_rdata;
  logic               r_err;

  logic               w_idx_bad;
  logic               w_bus_active;
  logic [A_WID-1:0]   w_addr_hot;

  assign w_idx_bad    = ({1'b0, req_idx} >= LP_NBANK);
  assign w_addr_hot   = A_WID'(1) << r_idx;
  assign w_bus_active = (r_state == S_WR) || (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);

  // Bus signals come from registered state only, never from req_* directly.
  assign addr      = w_bus_active ? w_addr_hot : '0;
  assign wr        = (r_state == S_WR);
  assign rd        = (r_state == S_RD_DATA);
  assign data      = wr ? r_wdata : 'z;

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_idx   <= req_idx;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= w_idx_bad;
            if (w_idx_bad)      r_state <= S_RSP;
            else if (req_write) r_state <= S_WR;
            else                r_state <= S_RD_ADDR;
          end
        end
        S_WR:      r_state <= S_RSP;
        S_RD_ADDR: r_state <= S_RD_DATA;
        S_RD_DATA: begin
          r_rdata <= data;
          r_state <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bid_bus_master.sv
// Directed bench for bid_bus_master with a bank-memory target model on the shared bus.
// Vector table drives single transactions; hand sequences cover stall and mid-read reset.
module tb_bid_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_idx;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [4:0] addr;
  logic       wr;
  logic       rd;
  wire  [7:0] data;

  int n_vec = 0;
  int n_err = 0;

  bid_bus_master #(.A_WID(5), .D_WID(8), .IDX_WID(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .wr(wr), .rd(rd), .data(data)
  );

  always #5 clk = ~clk;

  // Bank memory target: captures on wr, loads its output register during the address-only phase.
  logic [7:0] mem [5] = '{default: 8'h00};
  logic [7:0] r_tgt = 8'h00;

  function automatic int dec(input logic [4:0] a);
    int r = 0;
    for (int i = 0; i < 5; i++) if (a[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (wr) mem[dec(addr)] <= data;
    if (addr != 5'd0 && !wr && !rd) r_tgt <= mem[dec(addr)];
  end

  assign data = (rd && !wr) ? r_tgt : 'z;

  typedef struct {
    logic       write;
    logic [2:0] idx;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
    logic [4:0] exp_addr;
    int         exp_lat;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_addr"},      addr,      0);
    chk({tag, "_wr"},        wr,        0);
    chk({tag, "_rd"},        rd,        0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic run_txn(input vec_t v, input int stall);
    int lat;
    bit got;
    @(negedge clk);
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_write = v.write;
    req_idx   = v.idx;
    req_wdata = v.wdata;
    rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 8'h00;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      chk("wr_rd_exclusive", {31'd0, wr && rd}, 0);
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
      end else begin
        chk("bus_addr", addr, v.exp_addr);
        chk("bus_wr", wr, v.write);
        chk("bus_rd", rd, (!v.write && k == 2));
        chk("req_ready_busy", req_ready, 0);
        if (wr) chk("bus_wdata", data, v.wdata);
        if (rd) chk("bus_tgt_data", data, r_tgt);
      end
    end
    chk("rsp_latency", lat, v.exp_lat);
    if (got) begin
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);
      chk("rsp_err", rsp_err, v.exp_err);
      chk("rsp_addr_idle", addr, 0);
      chk("rsp_wr_idle", wr, 0);
      chk("rsp_rd_idle", rd, 0);
      chk("rsp_req_ready", req_ready, 0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("stall_req_ready", req_ready, 0);
        chk("stall_addr", addr, 0);
        chk("stall_rd", rd, 0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_return", req_ready, 1);
  endtask

  initial begin
    //          wr    idx   wdata  rdata  err   addr       lat
    vecs[0]  = '{1'b1, 3'd2, 8'hA5, 8'h00, 1'b0, 5'b00100, 2};
    vecs[1]  = '{1'b0, 3'd2, 8'h00, 8'hA5, 1'b0, 5'b00100, 3};
    vecs[2]  = '{1'b1, 3'd0, 8'h11, 8'h00, 1'b0, 5'b00001, 2};
    vecs[3]  = '{1'b1, 3'd1, 8'h22, 8'h00, 1'b0, 5'b00010, 2};
    vecs[4]  = '{1'b1, 3'd2, 8'h33, 8'h00, 1'b0, 5'b00100, 2};
    vecs[5]  = '{1'b1, 3'd3, 8'h44, 8'h00, 1'b0, 5'b01000, 2};
    vecs[6]  = '{1'b1, 3'd4, 8'h55, 8'h00, 1'b0, 5'b10000, 2};
    vecs[7]  = '{1'b0, 3'd4, 8'h00, 8'h55, 1'b0, 5'b10000, 3};
    vecs[8]  = '{1'b0, 3'd3, 8'h00, 8'h44, 1'b0, 5'b01000, 3};
    vecs[9]  = '{1'b0, 3'd2, 8'h00, 8'h33, 1'b0, 5'b00100, 3};
    vecs[10] = '{1'b0, 3'd1, 8'h00, 8'h22, 1'b0, 5'b00010, 3};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 8'h11, 1'b0, 5'b00001, 3};
    vecs[12] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 5'b00000, 1};
    vecs[13] = '{1'b1, 3'd7, 8'hEE, 8'h00, 1'b1, 5'b00000, 1};
    vecs[14] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 5'b00000, 1};

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_idx = 3'd0;
    req_wdata = 8'h00;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    for (int i = 0; i < 15; i++) run_txn(vecs[i], 0);

    // Response stalled for 4 cycles on a read of bank 3.
    run_txn('{1'b0, 3'd3, 8'h00, 8'h44, 1'b0, 5'b01000, 3}, 4);

    // Reset during RD_DATA: the aborted read must produce no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_idx   = 3'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rd_addr_phase", rd, 0);
    @(negedge clk);
    chk("abort_rd_data_phase", rd, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    run_txn('{1'b1, 3'd1, 8'h3C, 8'h00, 1'b0, 5'b00010, 2}, 0);
    run_txn('{1'b0, 3'd1, 8'h00, 8'h3C, 1'b0, 5'b00010, 3}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
